// File: rtl/rf_wb_arbiter.sv
// Round-robin arbiter sharing the register-file write port between NUM_REQ writeback sources.
// One registered output stage; writes to the zero register are absorbed and counted.
module rf_wb_arbiter #(
    parameter int NUM_REQ  = 3,
    parameter int DATA_W   = 64,
    parameter int ADDR_W   = 5,
    parameter int ZERO_REG = 31
) (
    input  logic                      clk_i,
    input  logic                      rst_i,
    input  logic                      stall_i,
    input  logic [NUM_REQ-1:0]        req_valid_i,
    input  logic [NUM_REQ*ADDR_W-1:0] req_addr_i,
    input  logic [NUM_REQ*DATA_W-1:0] req_data_i,
    output logic [NUM_REQ-1:0]        req_ready_o,
    output logic                      reg_write_o,
    output logic [ADDR_W-1:0]         wr_reg_o,
    output logic [DATA_W-1:0]         wr_data_o,
    output logic [31:0]               pend_mask_o,
    output logic [15:0]               drop_cnt_o
);

    localparam int PTR_W = $clog2(NUM_REQ);

    logic [PTR_W-1:0]  rr_ptr_q,    rr_ptr_d;
    logic              reg_write_q, reg_write_d;
    logic [ADDR_W-1:0] wr_reg_q,    wr_reg_d;
    logic [DATA_W-1:0] wr_data_q,   wr_data_d;
    logic [15:0]       drop_cnt_q,  drop_cnt_d;

    logic [NUM_REQ-1:0] grant;
    logic               xfer;
    logic [PTR_W-1:0]   gnt_idx;
    logic [ADDR_W-1:0]  sel_addr;
    logic [DATA_W-1:0]  sel_data;
    logic               sel_is_zero;

    // Scan starting at rr_ptr; the first valid requester wins.
    always_comb begin
        // NOTE: every signal gets a default before any conditional assignment, so no latch is inferred.
        grant    = '0;
        xfer     = 1'b0;
        gnt_idx  = '0;
        sel_addr = '0;
        sel_data = '0;
        if (!rst_i && !stall_i) begin
            for (int k = 0; k < NUM_REQ; k++) begin
                automatic int idx = (int'(rr_ptr_q) + k) % NUM_REQ;
                if (!xfer && req_valid_i[idx]) begin
                    xfer       = 1'b1;
                    grant[idx] = 1'b1;
                    gnt_idx    = PTR_W'(idx);
                    sel_addr   = req_addr_i[idx*ADDR_W +: ADDR_W];
                    sel_data   = req_data_i[idx*DATA_W +: DATA_W];
                end
            end
        end
    end

    assign sel_is_zero = (sel_addr == ADDR_W'(ZERO_REG));

    always_comb begin
        rr_ptr_d    = rr_ptr_q;
        reg_write_d = 1'b0;
        wr_reg_d    = wr_reg_q;
        wr_data_d   = wr_data_q;
        drop_cnt_d  = drop_cnt_q;
        if (xfer) begin
            rr_ptr_d = (gnt_idx == PTR_W'(NUM_REQ - 1)) ? '0 : gnt_idx + PTR_W'(1);
            if (sel_is_zero) begin
                if (drop_cnt_q != 16'hFFFF) begin
                    drop_cnt_d = drop_cnt_q + 16'd1;
                end
            end else begin
                reg_write_d = 1'b1;
                wr_reg_d    = sel_addr;
                wr_data_d   = sel_data;
            end
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            rr_ptr_q    <= '0;
            reg_write_q <= 1'b0;
            wr_reg_q    <= '0;
            wr_data_q   <= '0;
            drop_cnt_q  <= '0;
        end else begin
            // NOTE: state registers use non-blocking assignments so all flops update together at the edge.
            rr_ptr_q    <= rr_ptr_d;
            reg_write_q <= reg_write_d;
            wr_reg_q    <= wr_reg_d;
            wr_data_q   <= wr_data_d;
            drop_cnt_q  <= drop_cnt_d;
        end
    end

    always_comb begin
        pend_mask_o = '0;
        for (int i = 0; i < 32; i++) begin
            pend_mask_o[i] = reg_write_q && (int'(wr_reg_q) == i);
        end
    end

    assign req_ready_o = grant;
    assign reg_write_o = reg_write_q;
    assign wr_reg_o    = wr_reg_q;
    assign wr_data_o   = wr_data_q;
    assign drop_cnt_o  = drop_cnt_q;

endmodule

// File: tb/tb_rf_wb_arbiter.sv
// Directed bench for rf_wb_arbiter: expected write-port results are queued at grant time
// and compared one cycle later against the registered output stage.
module tb_rf_wb_arbiter;

    typedef struct {
        logic        we;
        logic [4:0]  a;
        logic [63:0] d;
    } exp_t;

    logic         clk = 1'b0;
    logic         rst;
    logic         stall;
    logic [2:0]   req_valid;
    logic [4:0]   addr [3];
    logic [63:0]  data [3];
    logic [14:0]  req_addr;
    logic [191:0] req_data;
    logic [2:0]   req_ready;
    logic         reg_write;
    logic [4:0]   wr_reg;
    logic [63:0]  wr_data;
    logic [31:0]  pend_mask;
    logic [15:0]  drop_cnt;

    exp_t        sb [$];
    int          n_cmp = 0;
    int          n_err = 0;
    logic [4:0]  exp_wr_reg  = '0;
    logic [63:0] exp_wr_data = '0;
    logic [15:0] exp_drop    = '0;

    assign req_addr = {addr[2], addr[1], addr[0]};
    assign req_data = {data[2], data[1], data[0]};

    always #5 clk = ~clk;

    rf_wb_arbiter #(.NUM_REQ(3), .DATA_W(64), .ADDR_W(5), .ZERO_REG(31)) dut (
        .clk_i       (clk),
        .rst_i       (rst),
        .stall_i     (stall),
        .req_valid_i (req_valid),
        .req_addr_i  (req_addr),
        .req_data_i  (req_data),
        .req_ready_o (req_ready),
        .reg_write_o (reg_write),
        .wr_reg_o    (wr_reg),
        .wr_data_o   (wr_data),
        .pend_mask_o (pend_mask),
        .drop_cnt_o  (drop_cnt)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_outputs(input string tag);
        check({tag, ".wr_reg"},  64'(wr_reg),    64'(exp_wr_reg));
        check({tag, ".wr_data"}, wr_data,        exp_wr_data);
        check({tag, ".drop"},    64'(drop_cnt),  64'(exp_drop));
    endtask

    // One cycle: drive, check the grant, queue the expected result, clock, compare the output stage.
    task automatic step(input string tag, input logic st, input logic [2:0] v, input logic [2:0] exp_rdy);
        exp_t e;
        exp_t got;
        int   g;
        stall     = st;
        req_valid = v;
        #1;
        check({tag, ".ready"}, 64'(req_ready), 64'(exp_rdy));
        e = '{we: 1'b0, a: 5'd0, d: 64'd0};
        if (exp_rdy != 3'b000) begin
            g = (exp_rdy == 3'b001) ? 0 : (exp_rdy == 3'b010) ? 1 : 2;
            if (addr[g] == 5'd31) begin
                if (exp_drop != 16'hFFFF) exp_drop = exp_drop + 16'd1;
            end else begin
                e = '{we: 1'b1, a: addr[g], d: data[g]};
            end
        end
        sb.push_back(e);
        @(posedge clk);
        #1;
        if (sb.size() == 0) begin
            check({tag, ".sb_empty"}, 64'd1, 64'd0);
        end else begin
            got = sb.pop_front();
            if (got.we) begin
                exp_wr_reg  = got.a;
                exp_wr_data = got.d;
            end
            check({tag, ".reg_write"}, 64'(reg_write), 64'(got.we));
            check({tag, ".pend"},      64'(pend_mask), 64'(32'(got.we) << got.a));
            check_outputs(tag);
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        // T1: reset with all requesters valid
        rst = 1'b1; stall = 1'b0; req_valid = 3'b111;
        for (int i = 0; i < 3; i++) begin
            addr[i] = 5'(i + 1);
            data[i] = 64'(i + 1);
        end
        repeat (2) @(posedge clk);
        #1;
        check("t1.ready",     64'(req_ready), 64'd0);
        check("t1.reg_write", 64'(reg_write), 64'd0);
        check("t1.pend",      64'(pend_mask), 64'd0);
        check_outputs("t1");
        rst = 1'b0;
        req_valid = 3'b000;

        // T2: single write from requester 1 (rr_ptr 0 -> 2)
        addr[1] = 5'd5; data[1] = 64'hDEAD_BEEF;
        step("t2.req", 1'b0, 3'b010, 3'b010);
        step("t2.idle", 1'b0, 3'b000, 3'b000);

        // Bring rr_ptr back to 0 via requester 2
        addr[2] = 5'd9; data[2] = 64'h0000_0009_0000_0009;
        step("t2b.req2", 1'b0, 3'b100, 3'b100);

        // T3: all valid, strict rotation; each requester drops after two transfers
        addr[0] = 5'd10; data[0] = 64'hA0;
        addr[1] = 5'd11; data[1] = 64'hB0;
        addr[2] = 5'd12; data[2] = 64'hC0;
        step("t3.g0a", 1'b0, 3'b111, 3'b001);
        addr[0] = 5'd13; data[0] = 64'hA1;
        step("t3.g1a", 1'b0, 3'b111, 3'b010);
        addr[1] = 5'd14; data[1] = 64'hB1;
        step("t3.g2a", 1'b0, 3'b111, 3'b100);
        addr[2] = 5'd30; data[2] = 64'hFFFF_FFFF_FFFF_FFC1;
        step("t3.g0b", 1'b0, 3'b111, 3'b001);
        step("t3.g1b", 1'b0, 3'b110, 3'b010);
        step("t3.g2b", 1'b0, 3'b100, 3'b100);
        step("t3.idle", 1'b0, 3'b000, 3'b000);

        // T4: XZR write from requester 0 is absorbed (rr_ptr 0 -> 1)
        addr[0] = 5'd31; data[0] = 64'h1234;
        step("t4.xzr", 1'b0, 3'b001, 3'b001);

        // T5: stall with all valid, then first grant at held rr_ptr = 1
        addr[0] = 5'd1; data[0] = 64'h11;
        addr[1] = 5'd2; data[1] = 64'h22;
        addr[2] = 5'd3; data[2] = 64'h33;
        for (int c = 0; c < 3; c++) step("t5.stall", 1'b1, 3'b111, 3'b000);
        step("t5.resume", 1'b0, 3'b111, 3'b010);
        step("t5.idle", 1'b0, 3'b000, 3'b000);

        // T6: transfer to X7, then reset during the output-stage cycle (rr_ptr = 2 -> grants 0)
        addr[0] = 5'd7; data[0] = 64'h7777;
        stall = 1'b0; req_valid = 3'b001;
        #1;
        check("t6.ready", 64'(req_ready), 64'd1);
        @(posedge clk);
        #1;
        check("t6.inflight", 64'(reg_write), 64'd1);
        check("t6.inflight_reg", 64'(wr_reg), 64'd7);
        rst = 1'b1;
        #1;
        check("t6.reg_write", 64'(reg_write), 64'd0);
        check("t6.pend",      64'(pend_mask), 64'd0);
        check("t6.ready_rst", 64'(req_ready), 64'd0);
        exp_wr_reg = '0; exp_wr_data = '0; exp_drop = '0;
        sb.delete();
        check_outputs("t6");
        @(posedge clk);
        #1;
        rst = 1'b0;
        req_valid = 3'b000;
        step("t6.after", 1'b0, 3'b000, 3'b000);
        // rr_ptr cleared by reset: requester 0 wins over 2
        addr[0] = 5'd8; data[0] = 64'h8888;
        step("t6.ptr0", 1'b0, 3'b101, 3'b001);
        step("t6.idle", 1'b0, 3'b000, 3'b000);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
